// File: rtl/jump_pkg.sv
// Shared J-type encoding constants, also used by the decoder-side jump shifter.
package jump_pkg;

    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_JAL  = 6'b000011;
    localparam int         JFIELD_W  = 26;
    localparam int         JFIELD_LO = 2;
    localparam int         JFIELD_HI = JFIELD_LO + JFIELD_W - 1;
    localparam int         PAGE_HI   = 31;
    localparam int         PAGE_LO   = 28;

    typedef struct packed {
        logic [31:0] instr;
        logic        err_page;
        logic        err_align;
    } jenc_entry_t;

    function automatic logic [31:0] make_j_instr(input logic link,
                                                 input logic [JFIELD_W-1:0] field);
        return {(link ? OPC_JAL : OPC_J), field};
    endfunction

endpackage

// File: rtl/jump_target_encoder_if.sv
// Request/response handshake bundle for the jump target encoder.
interface jump_target_encoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          pc;
    logic [31:0]          target;
    logic                 link;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          instr;
    logic                 err_page;
    logic                 err_align;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, pc, target, link, out_ready,
        input  in_ready, out_valid, instr, err_page, err_align, err_count
    );

    modport slave (
        input  in_valid, pc, target, link, out_ready,
        output in_ready, out_valid, instr, err_page, err_align, err_count
    );
endinterface

// File: rtl/jump_enc_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module jump_enc_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/jump_target_encoder.sv
// Builds j/jal instruction words from (pc, target) with page/alignment error flags.
module jump_target_encoder
    import jump_pkg::*;
#(
    parameter int FIFO_DEPTH = 3,
    parameter int ERR_CNT_W  = 8
) (
    input logic                  clk,
    input logic                  rst,
    jump_target_encoder_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 vld_p1;
    logic [31:0]          pc_p1;
    logic [31:0]          target_p1;
    logic                 link_p1;
    logic                 accept;
    logic [3:0]           pc4_page;
    jenc_entry_t          entry_p1;
    jenc_entry_t          head;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       occupancy;
    logic                 pop;
    logic [ERR_CNT_W-1:0] err_count;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Occupancy uses registered state only, so out_ready never reaches in_ready.
    assign occupancy = (CNT_W + 1)'(vld_p1) + (CNT_W + 1)'(fifo_count);
    assign bus.in_ready = !rst && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept = bus.in_valid && bus.in_ready;

    // ---- stage p0 -> p1: capture request ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_p1     <= bus.pc;
            target_p1 <= bus.target;
            link_p1   <= bus.link;
        end
    end

    // ---- stage p1: encode and flag, pushed into the output buffer ----
    assign pc4_page = 4'((pc_p1 + 32'd4) >> PAGE_LO);

    always_comb begin
        entry_p1           = '0;
        entry_p1.instr     = make_j_instr(link_p1, target_p1[JFIELD_HI:JFIELD_LO]);
        entry_p1.err_page  = (target_p1[PAGE_HI:PAGE_LO] != pc4_page);
        entry_p1.err_align = (target_p1[JFIELD_LO-1:0] != '0);
    end

    jump_enc_fifo #(
        .WIDTH ($bits(jenc_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data (entry_p1),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---- stage p2: buffer head presented to the consumer ----
    assign bus.out_valid = !fifo_empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.instr     = bus.out_valid ? head.instr : '0;
    assign bus.err_page  = bus.out_valid && head.err_page;
    assign bus.err_align = bus.out_valid && head.err_align;

    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (pop && (head.err_page || head.err_align))
            err_count <= sat_inc(err_count);
    end

    assign bus.err_count = err_count;

endmodule

// File: tb/tb_jump_target_encoder.sv
// Scoreboard bench for jump_target_encoder with a behavioural arithmetic model.
module tb_jump_target_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jump_target_encoder_if #(.ERR_CNT_W(8)) bus ();

    jump_target_encoder #(.FIFO_DEPTH(3), .ERR_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        pg;
        logic        al;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   exp_err = 0;
    int   acc_cnt = 0;
    int   pop_cnt = 0;
    bit   mon_en  = 1'b0;

    // Reference: opcode in the top 6 bits, word index within the 256 MB page below.
    function automatic exp_t model(input longint unsigned pc, input longint unsigned target,
                                   input bit link);
        exp_t e;
        longint unsigned pc4;
        longint unsigned word;
        pc4   = (pc + 4) % 64'h1_0000_0000;
        word  = (target % 64'h1000_0000) / 4;
        e.instr = 32'((link ? 64'd3 : 64'd2) * 64'h400_0000 + word);
        e.pg    = (target / 64'h1000_0000) != (pc4 / 64'h1000_0000);
        e.al    = (target % 4) != 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.pc, bus.target, bus.link));
            acc_cnt++;
        end
    end

    exp_t m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            check("err_count", 32'(bus.err_count), 32'(exp_err));
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(bus.out_valid), 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    check("instr", bus.instr, m_e.instr);
                    check("err_page", 32'(bus.err_page), 32'(m_e.pg));
                    check("err_align", 32'(bus.err_align), 32'(m_e.al));
                    if ((m_e.pg || m_e.al) && exp_err < 255) exp_err++;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        sb.delete();
        exp_err = 0;
        rst     = 1'b0;
        mon_en  = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_flags", {30'd0, bus.err_page, bus.err_align}, 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic directed(input logic [31:0] pc, input logic [31:0] target, input logic link,
                            input logic [31:0] x_instr, input logic x_pg, input logic x_al);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.pc        = pc;
        bus.target    = target;
        bus.link      = link;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check("dir_instr", bus.instr, x_instr);
        check("dir_err_page", 32'(bus.err_page), 32'(x_pg));
        check("dir_err_align", 32'(bus.err_align), 32'(x_al));
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic rand_payload(input bit force_err);
        logic [31:0] p;
        logic [31:0] t;
        p = $urandom();
        t = $urandom();
        if ($urandom_range(0, 1) == 0) t[31:28] = 4'((p + 32'd4) >> 28);
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        if (force_err) t[0] = 1'b1;
        bus.pc     = p;
        bus.target = t;
        bus.link   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        int p0;
        int stalls;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.pc        = '0;
        bus.target    = '0;
        bus.link      = 1'b0;

        do_reset();

        directed(32'h8000_0000, 32'h8FF0_38EC, 1'b0, 32'h0BFC_0E3B, 1'b0, 1'b0);
        directed(32'h8000_0000, 32'h8FF0_38EC, 1'b1, 32'h0FFC_0E3B, 1'b0, 1'b0);
        directed(32'h7FFF_FFFC, 32'h8000_0010, 1'b0, 32'h0800_0004, 1'b0, 1'b0);
        directed(32'h7FFF_FFFC, 32'h7000_0000, 1'b0, 32'h0800_0000, 1'b1, 1'b0);
        @(negedge clk);
        check("page_err_count", 32'(bus.err_count), 32'd1);
        directed(32'h8000_0000, 32'h8000_0002, 1'b0, 32'h0800_0000, 1'b0, 1'b1);
        directed(32'hFFFF_FFFC, 32'h0000_0040, 1'b0, 32'h0800_0010, 1'b0, 1'b0);
        drain();

        // Backpressure: five offered, three accepted.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        a0 = acc_cnt;
        repeat (5) begin
            bus.in_valid = 1'b1;
            rand_payload(1'b0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 32'(acc_cnt - a0), 32'd3);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_head", bus.instr, sb[0].instr);
        @(negedge clk);
        check("bp_head_stable", bus.instr, sb[0].instr);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        drain();

        // Throughput and saturation.
        do_reset();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        p0     = pop_cnt;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'b1;
            rand_payload(1'b1);
            @(negedge clk);
            if (!bus.in_ready) stalls++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("tp_stalls", 32'(stalls), 32'd0);
        check("tp_pops", 32'(pop_cnt - p0), 32'd300);
        @(negedge clk);
        check("sat_err_count", 32'(bus.err_count), 32'd255);

        // Reset with two buffered entries.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (2) begin
            bus.in_valid = 1'b1;
            rand_payload(1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_buffered", 32'(sb.size()), 32'd2);
        do_reset();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale_output", 32'(bus.out_valid), 32'd0);
        end

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rand_payload(1'b0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jump_target_encoder.md
# jump_target_encoder

Inverse of the jump-address shifter: given the address of a jump instruction and its desired absolute target, produces the 32-bit J-type instruction word (`j` or `jal`). It also flags targets that the 26-bit field cannot reach. It sits in the assembler/loader-side path that patches jump instructions in instruction memory. Requests are pipelined behind a valid/ready handshake so one encode per cycle is sustained.

## Interface
Parameters:
- `FIFO_DEPTH`, 3: output buffer entries. Minimum 3 for full throughput.
- `ERR_CNT_W`, 8: width of the saturating error counter.

Ports:
- `clk` input 1: single clock, all state changes on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: block accepts a request this cycle.
- `pc` input 32: byte address of the jump instruction.
- `target` input 32: desired absolute byte target.
- `link` input 1: 1 = `jal` (opcode 000011), 0 = `j` (opcode 000010).
- `out_valid` output 1: result at head of output buffer.
- `out_ready` input 1: consumer takes result.
- `instr` output 32: `{opcode, target[27:2]}`.
- `err_page` output 1: `target[31:28]` differs from `(pc+4)[31:28]`.
- `err_align` output 1: `target[1:0] != 0`.
- `err_count` output ERR_CNT_W: count of results with any error flag, saturating.

## Operation
- A transfer occurs when `in_valid && in_ready`; inputs are captured into stage S1 (`s1_valid`, payload).
- S1 computes `pc4 = pc + 4` (32-bit, modulo 2^32, wrap allowed), opcode, field `target[27:2]`, and both error flags. It then pushes `{instr, err_page, err_align}` into the output FIFO on the next edge.
- The FIFO is first-word-fall-through. `out_valid = !fifo_empty`, and the outputs show the head entry. A pop occurs on `out_valid && out_ready`.
- `in_ready = (s1_valid + fifo_count) < FIFO_DEPTH`, computed from registered state only, so there is no combinational path from `out_ready` to `in_ready`.
- The FIFO push and pop may occur in the same cycle. `fifo_count` is then unchanged, and full/empty pointers wrap modulo FIFO_DEPTH.
- Errors do not suppress output. `instr` is always formed from `target[27:2]`, and the flags accompany it.
- `err_count` increments by 1 on each pop whose entry has `err_page || err_align`. It holds at all-ones.
- Reset values: `s1_valid=0`, FIFO empty, `out_valid=0`, `in_ready=0` during the reset cycle and 1 after. `instr=0`, `err_page=0`, `err_align=0`, `err_count=0`.
- Reset mid-operation: all in-flight and buffered requests are discarded with no output, and `err_count` is cleared.

## Timing
- Latency: a request accepted at edge E0 appears with `out_valid=1` in the cycle after edge E1, which is 2 cycles from presentation.
- Throughput: 1 result per cycle with `out_ready` held high and `in_valid` continuous. Steady state is `s1_valid=1`, `fifo_count=1`.
- Backpressure: with `out_ready=0`, at most FIFO_DEPTH requests are accepted, then `in_ready` deasserts. It reasserts the cycle after the first pop.
- S1 advances unconditionally, because the occupancy rule guarantees FIFO space.
- Head outputs remain stable while `out_valid && !out_ready`.

## Structure
- Shared package `jump_pkg`: `OPC_J = 6'b000010`, `OPC_JAL = 6'b000011`, `JFIELD_W = 26`, and the page bit range constants `[31:28]`. The decoder-side shifter uses the same constants.
- One sub-module, `jump_enc_fifo`: a parameterised sync FWFT FIFO (width 34, depth FIFO_DEPTH) with count output.
- S1 logic and `err_count` live in the top.

## Test plan
- Basic `j`: pc=0x80000000, target=0x8FF038EC, link=0 → after 2 cycles, instr=0x0BFC0E3B, no errors. With link=1 → instr=0x0FFC0E3B.
- Page boundary: pc=0x7FFFFFFC, target=0x80000010 → instr=0x08000004, err_page=0. The same pc with target=0x70000000 → err_page=1, err_count=1 after pop.
- Misaligned and wrap: target=0x80000002, pc=0x80000000 → err_align=1, instr=0x08000000. pc=0xFFFFFFFC, target=0x00000040 → err_page=0, instr=0x08000010.
- Backpressure: hold out_ready=0 and stream 5 requests → exactly 3 accepted and in_ready=0. Then release → results come out in order with no loss or duplication, and in_ready returns.
- Throughput and saturation: 300 back-to-back erroneous requests with out_ready=1 → one result per cycle after 2-cycle fill, and err_count stops at 255.
- Reset mid-stream: assert rst with 2 buffered entries → next cycle out_valid=0 and err_count=0, and no stale result ever appears.
